// File: rtl/servo_axis_sequencer.sv
// Multi-axis servo jog/seek sequencer with a bounded position tracker per axis
// and a fire/recoil timing sequencer; all outputs are registered command codes.
module servo_axis_lane #(
    parameter int POS_W   = 25,
    parameter int POS_MAX = 22727272,
    parameter int STEP    = 1,
    parameter int CMD_W   = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             manual_i,
    input  logic             jog_neg_i,
    input  logic             jog_pos_i,
    input  logic [POS_W-1:0] target_i,
    output logic [CMD_W-1:0] cmd_o,
    output logic [POS_W-1:0] pos_o,
    output logic             on_target_o,
    output logic [1:0]       led_o
);
    // State encoding doubles as the command code driven to the PWM stage.
    typedef enum logic [2:0] {
        AX_IDLE = 3'd0,
        AX_NEG  = 3'd1,
        AX_POS  = 3'd2,
        AX_REL  = 3'd5
    } ax_state_e;

    localparam logic [POS_W-1:0] PMAX  = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] STEPV = POS_W'(STEP);

    ax_state_e        state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d, tgt_c, pos_dn, pos_up;
    logic             want_neg, want_pos;
    logic [CMD_W-1:0] cmd_q;
    logic             ont_q;
    logic [1:0]       led_q;

    always_comb begin
        tgt_c    = (target_i > PMAX) ? PMAX : target_i;
        want_neg = manual_i ? (jog_neg_i & ~jog_pos_i) : (pos_q > tgt_c);
        want_pos = manual_i ? (jog_pos_i & ~jog_neg_i) : (pos_q < tgt_c);

        state_d = state_q;
        case (state_q)
            AX_IDLE: begin
                if (want_neg)      state_d = AX_NEG;
                else if (want_pos) state_d = AX_POS;
            end
            AX_NEG:  state_d = want_neg ? AX_NEG : AX_REL;
            AX_POS:  state_d = want_pos ? AX_POS : AX_REL;
            default: state_d = AX_IDLE;
        endcase

        // Saturating step; in seek mode also clipped so it lands on the target.
        pos_dn = (pos_q >= STEPV) ? pos_q - STEPV : '0;
        pos_up = ((PMAX - pos_q) >= STEPV) ? pos_q + STEPV : PMAX;
        pos_d  = pos_q;
        if (state_d == AX_NEG)
            pos_d = (!manual_i && pos_dn < tgt_c) ? tgt_c : pos_dn;
        else if (state_d == AX_POS)
            pos_d = (!manual_i && pos_up > tgt_c) ? tgt_c : pos_up;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= AX_IDLE;
            pos_q   <= '0;
            cmd_q   <= '0;
            ont_q   <= 1'b0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            cmd_q   <= CMD_W'(state_d);
            ont_q   <= !manual_i && (pos_d == tgt_c);
            led_q   <= {state_d == AX_POS, state_d == AX_NEG};
        end
    end

    assign cmd_o       = cmd_q;
    assign pos_o       = pos_q;
    assign on_target_o = ont_q;
    assign led_o       = led_q;
endmodule

module servo_axis_sequencer #(
    parameter int N_AXES       = 2,
    parameter int POS_W        = 25,
    parameter int POS_MAX      = 22727272,
    parameter int STEP         = 1,
    parameter int CMD_W        = 4,
    parameter int FIRE_TICKS   = 22727272,
    parameter int RECOIL_TICKS = 22727272
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic                    i_Manual,
    input  logic [N_AXES-1:0]       i_Jog_Neg,
    input  logic [N_AXES-1:0]       i_Jog_Pos,
    input  logic [N_AXES*POS_W-1:0] i_Target,
    input  logic                    i_Fire,
    output logic [N_AXES*CMD_W-1:0] o_Axis_Cmd,
    output logic [N_AXES*POS_W-1:0] o_Axis_Pos,
    output logic [N_AXES-1:0]       o_On_Target,
    output logic [CMD_W-1:0]        o_Fire_Cmd,
    output logic                    o_Fire_Busy,
    output logic [2*N_AXES-1:0]     o_LED
);
    localparam int TMAX  = (FIRE_TICKS > RECOIL_TICKS) ? FIRE_TICKS : RECOIL_TICKS;
    localparam int CNT_W = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        NOT_FIRE = 2'd0,
        FIRE     = 2'd1,
        RECOIL   = 2'd2
    } fire_state_e;

    logic [N_AXES-1:0] on_tgt;

    for (genvar k = 0; k < N_AXES; k++) begin : g_axis
        servo_axis_lane #(
            .POS_W  (POS_W),
            .POS_MAX(POS_MAX),
            .STEP   (STEP),
            .CMD_W  (CMD_W)
        ) u_lane (
            .clk_i      (i_Clk),
            .rst_i      (i_Rst),
            .manual_i   (i_Manual),
            .jog_neg_i  (i_Jog_Neg[k]),
            .jog_pos_i  (i_Jog_Pos[k]),
            .target_i   (i_Target[k*POS_W +: POS_W]),
            .cmd_o      (o_Axis_Cmd[k*CMD_W +: CMD_W]),
            .pos_o      (o_Axis_Pos[k*POS_W +: POS_W]),
            .on_target_o(on_tgt[k]),
            .led_o      (o_LED[2*k +: 2])
        );
    end

    assign o_On_Target = on_tgt;

    fire_state_e      fstate_q;
    logic [CNT_W-1:0] fcnt_q;
    logic             fire_prev_q;
    logic [CMD_W-1:0] fire_cmd_q;
    logic             busy_q;

    // fire_prev_q tracks the button even while busy, so a held button never retriggers.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            fstate_q    <= NOT_FIRE;
            fcnt_q      <= '0;
            fire_prev_q <= 1'b0;
            fire_cmd_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            fire_prev_q <= i_Fire;
            case (fstate_q)
                NOT_FIRE: begin
                    if (i_Fire && !fire_prev_q && (i_Manual || (&on_tgt))) begin
                        fstate_q   <= FIRE;
                        fcnt_q     <= '0;
                        fire_cmd_q <= CMD_W'(FIRE);
                        busy_q     <= 1'b1;
                    end
                end
                FIRE: begin
                    if (fcnt_q == CNT_W'(FIRE_TICKS - 1)) begin
                        fstate_q   <= RECOIL;
                        fcnt_q     <= '0;
                        fire_cmd_q <= CMD_W'(RECOIL);
                    end else begin
                        fcnt_q <= fcnt_q + 1'b1;
                    end
                end
                default: begin
                    if (fcnt_q == CNT_W'(RECOIL_TICKS - 1)) begin
                        fstate_q   <= NOT_FIRE;
                        fcnt_q     <= '0;
                        fire_cmd_q <= CMD_W'(NOT_FIRE);
                        busy_q     <= 1'b0;
                    end else begin
                        fcnt_q <= fcnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign o_Fire_Cmd  = fire_cmd_q;
    assign o_Fire_Busy = busy_q;
endmodule

// File: tb/tb_servo_axis_sequencer.sv
// Bench for servo_axis_sequencer: scenario tasks plus random stimulus, each
// cycle compared against a direction/queue level model of the sequencer.
module tb_servo_axis_sequencer;
    localparam int N     = 2;
    localparam int POS_W = 8;
    localparam int PMAX  = 10;
    localparam int STEP  = 3;
    localparam int CMD_W = 4;
    localparam int FT    = 4;
    localparam int RT    = 3;
    localparam int TOTW  = N*CMD_W + N*POS_W + N + CMD_W + 1 + 2*N;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               manual = 1'b1;
    logic [N-1:0]       jog_neg = '0;
    logic [N-1:0]       jog_pos = '0;
    logic [N*POS_W-1:0] target = '0;
    logic               fire = 1'b0;
    logic [N*CMD_W-1:0] axis_cmd;
    logic [N*POS_W-1:0] axis_pos;
    logic [N-1:0]       on_target;
    logic [CMD_W-1:0]   fire_cmd;
    logic               fire_busy;
    logic [2*N-1:0]     led;
    logic [TOTW-1:0]    dut_vec;

    int checks = 0;
    int failures = 0;

    servo_axis_sequencer #(
        .N_AXES(N), .POS_W(POS_W), .POS_MAX(PMAX), .STEP(STEP), .CMD_W(CMD_W),
        .FIRE_TICKS(FT), .RECOIL_TICKS(RT)
    ) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Manual(manual), .i_Jog_Neg(jog_neg),
        .i_Jog_Pos(jog_pos), .i_Target(target), .i_Fire(fire),
        .o_Axis_Cmd(axis_cmd), .o_Axis_Pos(axis_pos), .o_On_Target(on_target),
        .o_Fire_Cmd(fire_cmd), .o_Fire_Busy(fire_busy), .o_LED(led)
    );

    always #5 clk = ~clk;

    assign dut_vec = {axis_cmd, axis_pos, on_target, fire_cmd, fire_busy, led};

    // Model: each axis is a direction (-1/0/+1) plus a one-cycle "releasing" flag;
    // the fire sequence is a queue of the codes still to be shown.
    int m_pos [N];
    int m_dir [N];
    bit m_rel [N];
    bit m_ont [N];
    int fq [$];
    int m_fcmd;
    bit m_fire_prev;

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            m_pos[k] = 0; m_dir[k] = 0; m_rel[k] = 0; m_ont[k] = 0;
        end
        fq.delete();
        m_fcmd = 0;
        m_fire_prev = 0;
    endfunction

    function automatic void model_step();
        bit all_on = 1;
        for (int k = 0; k < N; k++) all_on &= m_ont[k];
        if (fq.size() > 0) begin
            m_fcmd = fq.pop_front();
        end else if (m_fcmd == 0 && fire && !m_fire_prev && (manual || all_on)) begin
            for (int i = 0; i < FT; i++) fq.push_back(1);
            for (int i = 0; i < RT; i++) fq.push_back(2);
            m_fcmd = fq.pop_front();
        end else begin
            m_fcmd = 0;
        end
        m_fire_prev = fire;

        for (int k = 0; k < N; k++) begin
            int tgt, req, np;
            bit wn, wp;
            tgt = int'(target[k*POS_W +: POS_W]);
            if (tgt > PMAX) tgt = PMAX;
            wn = manual ? (jog_neg[k] && !jog_pos[k]) : (m_pos[k] > tgt);
            wp = manual ? (jog_pos[k] && !jog_neg[k]) : (m_pos[k] < tgt);
            req = wp ? 1 : (wn ? -1 : 0);
            if (m_rel[k]) begin
                m_rel[k] = 0;
                m_dir[k] = 0;
            end else if (m_dir[k] == 0) begin
                m_dir[k] = req;
            end else if (req != m_dir[k]) begin
                m_dir[k] = 0;
                m_rel[k] = 1;
            end
            np = m_pos[k];
            if (m_dir[k] == 1) begin
                np = np + STEP;
                if (np > PMAX) np = PMAX;
                if (!manual && np > tgt) np = tgt;
            end else if (m_dir[k] == -1) begin
                np = np - STEP;
                if (np < 0) np = 0;
                if (!manual && np < tgt) np = tgt;
            end
            m_pos[k] = np;
            m_ont[k] = !manual && (np == tgt);
        end
    endfunction

    function automatic logic [TOTW-1:0] exp_vec();
        logic [N*CMD_W-1:0] c;
        logic [N*POS_W-1:0] p;
        logic [N-1:0]       o;
        logic [2*N-1:0]     l;
        for (int k = 0; k < N; k++) begin
            c[k*CMD_W +: CMD_W] = m_rel[k] ? CMD_W'(5) :
                                  (m_dir[k] == 1) ? CMD_W'(2) :
                                  (m_dir[k] == -1) ? CMD_W'(1) : CMD_W'(0);
            p[k*POS_W +: POS_W] = POS_W'(m_pos[k]);
            o[k]                = m_ont[k];
            l[2*k]              = (m_dir[k] == -1);
            l[2*k+1]            = (m_dir[k] == 1);
        end
        return {c, p, o, CMD_W'(m_fcmd), (m_fcmd != 0), l};
    endfunction

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fire = 1'b0;
        jog_neg = '0;
        jog_pos = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        model_reset();
        #3;
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL reset_async got=%h exp=%h", dut_vec, exp_vec());
        end
        @(posedge clk);
        #1;
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL reset_held got=%h exp=%h", dut_vec, exp_vec());
        end
        rst = 1'b0;
    endtask

    task automatic test_manual_jog();
        do_reset();
        manual = 1'b1;
        jog_pos = 2'b01;
        for (int i = 0; i < 14; i++) begin
            if (i == 8) jog_pos = '0;
            cycle();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL manual_jog cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        // Jog back down past zero to exercise the lower bound.
        jog_neg = 2'b01;
        for (int i = 0; i < 6; i++) begin
            cycle();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL manual_jog_neg cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        jog_neg = '0;
    endtask

    task automatic test_both_buttons();
        do_reset();
        manual = 1'b1;
        jog_neg = 2'b10;
        jog_pos = 2'b10;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) jog_pos = '0;
            cycle();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL both_buttons cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        jog_neg = '0;
    endtask

    task automatic test_auto_seek();
        do_reset();
        manual = 1'b0;
        target = {8'd20, 8'd7};
        for (int i = 0; i < 7; i++) begin
            cycle();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL auto_seek cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if (on_target !== 2'b11 || axis_pos !== {8'd10, 8'd7}) begin
            failures++;
            $display("FAIL auto_seek_final got=%b/%h exp=11/0a07", on_target, axis_pos);
        end
        target = {8'd2, 8'd1};
        for (int i = 0; i < 6; i++) begin
            cycle();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL auto_seek_down cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_fire_gate();
        do_reset();
        manual = 1'b0;
        target = {8'd9, 8'd5};
        for (int i = 0; i < 20; i++) begin
            fire = (i == 0 || i == 6);
            cycle();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL fire_gate cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        fire = 1'b0;
    endtask

    task automatic test_fire_hold();
        do_reset();
        manual = 1'b1;
        for (int i = 0; i < 24; i++) begin
            fire = !(i == 10 || i == 16);
            cycle();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL fire_hold cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        fire = 1'b0;
    endtask

    task automatic test_mode_change();
        do_reset();
        manual = 1'b0;
        target = {8'd0, 8'd10};
        for (int i = 0; i < 6; i++) begin
            if (i == 2) manual = 1'b1;
            cycle();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL mode_change cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) manual = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) target = (N*POS_W)'($urandom_range(0, 16'hffff) & 16'h0f0f);
            jog_neg = N'($urandom_range(0, 3));
            jog_pos = N'($urandom_range(0, 3));
            fire = ($urandom_range(0, 5) == 0);
            cycle();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        fire = 1'b0;
        jog_neg = '0;
        jog_pos = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        manual = 1'b1;
        jog_pos = 2'b01;
        cycle();
        cycle();
        jog_pos = '0;
        fire = 1'b1;
        cycle();
        fire = 1'b0;
        cycle();
        checks++;
        if (fire_cmd !== 4'd1 || axis_pos[POS_W-1:0] !== 8'd6) begin
            failures++;
            $display("FAIL pre_reset got=%0d/%0d exp=1/6", fire_cmd, axis_pos[POS_W-1:0]);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", dut_vec, exp_vec());
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_manual_jog();
        test_both_buttons();
        test_auto_seek();
        test_fire_gate();
        test_fire_hold();
        test_mode_change();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
